// File: rtl/edge_pkg.sv
// Shared definitions for the streaming edge detector: FSM states, kernel modes
// and gradient/magnitude width helpers.
package edge_pkg;

    typedef enum logic [1:0] {IDLE, READ, FLUSH, FINISH} state_t;

    localparam logic MODE_SOBEL   = 1'b0;
    localparam logic MODE_PREWITT = 1'b1;

    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

    function automatic int mag_w(input int pix_w);
        return 2 * (pix_w + 3) + 1;
    endfunction

endpackage

// File: rtl/edge_line_buffer.sv
// Simple dual-port line memory, one write and one registered read per cycle.
module edge_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sobel_stream_edge_detector.sv
// Streaming 3x3 Sobel/Prewitt edge detector with two line buffers.
// Optional macro EDGE_MAG_OUT_EN adds the squared-magnitude output port mag.
module sobel_stream_edge_detector
    import edge_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int PIX_W       = 10,
    parameter int DATA_W      = 36,
    parameter int PIX_LSB     = 20,
    parameter int ADDR_W      = 19,
    parameter int RD_LAT      = 2,
    parameter int THRES_W     = 7,
    parameter int THRES_SHIFT = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic              write_data,
    output logic              write_en,
    input  logic [THRES_W-1:0] thres,
    input  logic              mode
`ifdef EDGE_MAG_OUT_EN
    ,
    output logic [2*(PIX_W+3):0] mag
`endif
);

    localparam int X_W    = $clog2(WIDTH);
    localparam int Y_W    = $clog2(HEIGHT);
    localparam int GRAD_W = grad_w(PIX_W);
    localparam int SQ_W   = 2 * GRAD_W;
    localparam int MAG_W  = mag_w(PIX_W);
    localparam int SUM_W  = PIX_W + 2;
    localparam int K_W    = $clog2(WIDTH * HEIGHT + WIDTH + 2);
    localparam int CMP_W  = (MAG_W > THRES_W + THRES_SHIFT) ? MAG_W : THRES_W + THRES_SHIFT;
    localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'({Y_LAST, X_LAST});

    state_t              state;
    logic [X_W-1:0]      rx, ax, cx, lb_raddr;
    logic [Y_W-1:0]      ry, cy;
    logic [X_W:0]        flush_cnt;
    logic                iss_v, iss_virt, mode_q;
    logic [THRES_W-1:0]  thres_q;
    logic [RD_LAT-1:0]   vpipe, virtpipe;
    logic [K_W-1:0]      ak;
    logic                in_valid, win_v, s1_v, s2_v, unused_bits;
    logic [PIX_W-1:0]    in_pix, lb0_q, lb1_q;
    logic [PIX_W-1:0]    c1_t, c1_m, c1_b, c2_t, c2_m, c2_b;
    logic [PIX_W-1:0]    t0, t1, t2, m0, m2, b0, b1, b2;
    logic                lft_ok, rgt_ok, top_ok, bot_ok, prewitt, edge_c;
    logic [SUM_W-1:0]    sum_l, sum_r, sum_t, sum_b;
    logic [GRAD_W-1:0]   gx_c, gy_c, s1_gx, s1_gy;
    logic [SQ_W-1:0]     gx_ext, gy_ext, s2_sqx, s2_sqy;
    logic [MAG_W-1:0]    mag_c;
    logic [ADDR_W-1:0]   s1_addr, s2_addr;

    function automatic logic [SUM_W-1:0] wsum(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] c,
                                              input logic [PIX_W-1:0] b, input logic unit_w);
        logic [SUM_W-1:0] cw;
        cw = unit_w ? SUM_W'(c) : SUM_W'(c) << 1;
        return SUM_W'(a) + cw + SUM_W'(b);
    endfunction

    // Read-side control: address generation, flush of virtual pixels, done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;  busy <= 1'b0;  done <= 1'b0;
            rx <= '0;  ry <= '0;  read_addr <= '0;  flush_cnt <= '0;
            iss_v <= 1'b0;  iss_virt <= 1'b0;  thres_q <= '0;  mode_q <= MODE_SOBEL;
        end else if (start) begin
            state <= READ;  busy <= 1'b1;  done <= 1'b0;
            rx <= '0;  ry <= '0;  read_addr <= '0;  flush_cnt <= '0;
            iss_v <= 1'b1;  iss_virt <= 1'b0;  thres_q <= thres;  mode_q <= mode;
        end else begin
            case (state)
                READ: begin
                    if (rx == X_LAST && ry == Y_LAST) begin
                        state    <= FLUSH;
                        iss_virt <= 1'b1;
                    end else if (rx == X_LAST) begin
                        rx        <= '0;
                        ry        <= ry + 1'b1;
                        read_addr <= ADDR_W'({ry + 1'b1, X_W'(0)});
                    end else begin
                        rx        <= rx + 1'b1;
                        read_addr <= ADDR_W'({ry, rx + 1'b1});
                    end
                end
                FLUSH: begin
                    if (iss_v) begin
                        if (flush_cnt == (X_W+1)'(WIDTH)) iss_v <= 1'b0;
                        else flush_cnt <= flush_cnt + 1'b1;
                    end
                    if (write_en && write_addr == LAST_ADDR) begin
                        state <= FINISH;  busy <= 1'b0;  done <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;  done <= 1'b0;  iss_virt <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_valid    = vpipe[RD_LAT-1];
    assign in_pix      = virtpipe[RD_LAT-1] ? '0 : read_data[PIX_LSB +: PIX_W];
    assign win_v       = in_valid && (ak >= K_W'(WIDTH + 1));
    assign unused_bits = ^read_data;
    // Line buffers are read one cycle ahead, at the column of the next arriving pixel.
    assign lb_raddr    = !in_valid ? ax : (ax == X_LAST) ? '0 : ax + 1'b1;

    edge_line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb0 (
        .clk(clk), .we(in_valid), .waddr(ax), .wdata(in_pix), .raddr(lb_raddr), .rdata(lb0_q));
    edge_line_buffer #(.DEPTH(WIDTH), .DATA_W(PIX_W)) u_lb1 (
        .clk(clk), .we(in_valid), .waddr(ax), .wdata(lb0_q), .raddr(lb_raddr), .rdata(lb1_q));

    // Right window column is the live pixel plus the two line-buffer outputs.
    always_comb begin
        lft_ok  = (cx != '0);
        rgt_ok  = (cx != X_LAST);
        top_ok  = (cy != '0);
        bot_ok  = (cy != Y_LAST);
        prewitt = (mode_q == MODE_PREWITT);
        t0 = (lft_ok && top_ok) ? c2_t  : '0;
        t1 = top_ok             ? c1_t  : '0;
        t2 = (rgt_ok && top_ok) ? lb1_q : '0;
        m0 = lft_ok             ? c2_m  : '0;
        m2 = rgt_ok             ? lb0_q : '0;
        b0 = (lft_ok && bot_ok) ? c2_b  : '0;
        b1 = bot_ok             ? c1_b  : '0;
        b2 = (rgt_ok && bot_ok) ? in_pix : '0;
        sum_l = wsum(t0, m0, b0, prewitt);
        sum_r = wsum(t2, m2, b2, prewitt);
        sum_t = wsum(t0, t1, t2, prewitt);
        sum_b = wsum(b0, b1, b2, prewitt);
        gx_c  = GRAD_W'(sum_r) - GRAD_W'(sum_l);
        gy_c  = GRAD_W'(sum_b) - GRAD_W'(sum_t);
        gx_ext = {{GRAD_W{s1_gx[GRAD_W-1]}}, s1_gx};
        gy_ext = {{GRAD_W{s1_gy[GRAD_W-1]}}, s1_gy};
        mag_c  = MAG_W'(s2_sqx) + MAG_W'(s2_sqy);
        edge_c = CMP_W'(mag_c) > (CMP_W'(thres_q) << THRES_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vpipe <= '0;  virtpipe <= '0;  ax <= '0;  ak <= '0;  cx <= '0;  cy <= '0;
            s1_v <= 1'b0;  s2_v <= 1'b0;  write_en <= 1'b0;  write_data <= 1'b0;  write_addr <= '0;
`ifdef EDGE_MAG_OUT_EN
            mag <= '0;
`endif
        end else if (start) begin
            vpipe <= '0;  virtpipe <= '0;  ax <= '0;  ak <= '0;  cx <= '0;  cy <= '0;
            s1_v <= 1'b0;  s2_v <= 1'b0;  write_en <= 1'b0;
        end else begin
            vpipe    <= RD_LAT'({vpipe, iss_v});
            virtpipe <= RD_LAT'({virtpipe, iss_virt});
            if (in_valid) begin
                ax <= (ax == X_LAST) ? '0 : ax + 1'b1;
                ak <= ak + 1'b1;
            end
            if (win_v) begin
                cx <= (cx == X_LAST) ? '0 : cx + 1'b1;
                if (cx == X_LAST) cy <= cy + 1'b1;
            end
            s1_v     <= win_v;
            s2_v     <= s1_v;
            write_en <= s2_v;
            if (s2_v) begin
                write_data <= edge_c;
                write_addr <= s2_addr;
`ifdef EDGE_MAG_OUT_EN
                mag <= mag_c;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            c2_t <= c1_t;   c2_m <= c1_m;   c2_b <= c1_b;
            c1_t <= lb1_q;  c1_m <= lb0_q;  c1_b <= in_pix;
        end
        if (win_v) begin
            s1_gx   <= gx_c;
            s1_gy   <= gy_c;
            s1_addr <= ADDR_W'({cy, cx});
        end
        if (s1_v) begin
            s2_sqx  <= gx_ext * gx_ext;
            s2_sqy  <= gy_ext * gy_ext;
            s2_addr <= s1_addr;
        end
    end

endmodule

// File: tb/tb_sobel_stream_edge_detector.sv
// Directed bench for sobel_stream_edge_detector on an 8x6 frame with a reference convolution model.
module tb_sobel_stream_edge_detector;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;
    localparam int DATA_W = 36;
    localparam int PIX_LSB = 20;
    localparam int ADDR_W = 19;
    localparam int MAXLOG = 1024;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, write_data, write_en;
    logic [ADDR_W-1:0] read_addr, write_addr;
    logic [DATA_W-1:0] read_data;
    logic [6:0]        thres = '0;
    logic              mode = 1'b0;
`ifdef EDGE_MAG_OUT_EN
    logic [26:0]       mag;
`endif

    sobel_stream_edge_detector #(
        .WIDTH(W), .HEIGHT(H), .PIX_W(10), .DATA_W(DATA_W), .PIX_LSB(PIX_LSB),
        .ADDR_W(ADDR_W), .RD_LAT(2), .THRES_W(7), .THRES_SHIFT(17)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .read_addr(read_addr), .read_data(read_data), .write_addr(write_addr),
        .write_data(write_data), .write_en(write_en), .thres(thres), .mode(mode)
`ifdef EDGE_MAG_OUT_EN
        , .mag(mag)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int img [N];
    logic [DATA_W-1:0] rd_q [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] mkword(input int a);
        logic [DATA_W-1:0] w;
        w = '1;
        w[PIX_LSB +: 10] = (a < N) ? img[a][9:0] : 10'd0;
        return w;
    endfunction

    always @(posedge clk) begin
        rd_q[1] <= rd_q[0];
        rd_q[0] <= mkword(int'(read_addr));
    end
    assign read_data = rd_q[1];

    // Output log; written only by this monitor.
    int wr_n = 0, done_n = 0, done_cyc = 0;
    logic busy_at_done = 1'b0;
    int wr_addr [MAXLOG];
    int wr_data [MAXLOG];
    int wr_cyc  [MAXLOG];
    int wr_mag  [MAXLOG];

    always begin
        @(posedge clk);
        #1;
        if (write_en) begin
            if (wr_n < MAXLOG) begin
                wr_addr[wr_n] = int'(write_addr);
                wr_data[wr_n] = int'(write_data);
                wr_cyc[wr_n]  = cyc;
`ifdef EDGE_MAG_OUT_EN
                wr_mag[wr_n]  = int'(mag);
`else
                wr_mag[wr_n]  = 0;
`endif
            end
            wr_n++;
        end
        if (done) begin
            if (done_n == 0 || 1'b1) begin
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            done_n++;
        end
    end

    int n_vec = 0, n_err = 0;
    int wb = 0, db = 0, t_start = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pix(input int x, input int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 0;
        return img[y*W + x];
    endfunction

    function automatic int exp_mag(input int x, input int y, input logic prew);
        int wt, gx, gy, k;
        wt = prew ? 1 : 2;
        gx = 0;
        gy = 0;
        for (int d = -1; d <= 1; d++) begin
            k = (d == 0) ? wt : 1;
            gx += k * (pix(x + 1, y + d) - pix(x - 1, y + d));
            gy += k * (pix(x + d, y + 1) - pix(x + d, y - 1));
        end
        return gx*gx + gy*gy;
    endfunction

    task automatic pulse_start(input int th, input logic md);
        @(negedge clk);
        thres = 7'(th);
        mode = md;
        start = 1'b1;
        wb = wr_n;
        db = done_n;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        thres = ~7'(th);
        mode = ~md;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_writes(input string tag, input int n);
        int guard = 0;
        while (wr_n - wb < n && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_reach_write"}, (wr_n - wb >= n), 1);
    endtask

    task automatic check_frame(input string tag, input int th, input logic md);
        int guard = 0;
        int i, x, y, m;
        while (done_n == db && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_done_count"}, done_n - db, 1);
        check({tag, "_write_count"}, wr_n - wb, N);
        for (int j = 0; j < N; j++) begin
            i = wb + j;
            if (i < MAXLOG) begin
                x = j % W;
                y = j / W;
                m = exp_mag(x, y, md);
                check({tag, "_addr"}, wr_addr[i], j);
                check({tag, "_cycle"}, wr_cyc[i], t_start + 15 + j);
                check({tag, "_edge"}, wr_data[i], (m > (th << 17)) ? 1 : 0);
`ifdef EDGE_MAG_OUT_EN
                check({tag, "_mag"}, wr_mag[i], m);
`endif
            end
        end
        check({tag, "_done_cycle"}, done_cyc, wr_cyc[wb + N - 1] + 1);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_write_en"}, write_en, 0);
        check({tag, "_write_data"}, write_data, 0);
        check({tag, "_read_addr"}, read_addr, 0);
        check({tag, "_write_addr"}, write_addr, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // Uniform 100, Sobel, thres 1: only border pixels exceed 131072.
        for (int i = 0; i < N; i++) img[i] = 100;
        pulse_start(1, 1'b0);
        check_frame("uniform", 1, 1'b0);
        check("uniform_corner_edge", wr_data[wb], 1);
        check("uniform_inner_edge", wr_data[wb + 9], 0);
        check("uniform_inner_edge2", wr_data[wb + 3*W + 4], 0);
`ifdef EDGE_MAG_OUT_EN
        check("uniform_corner_mag", wr_mag[wb], 180000);
        check("uniform_inner_mag", wr_mag[wb + 9], 0);
`endif

        // Vertical step at x=3|4: Sobel 4092^2 beats 127<<17, Prewitt 3069^2 does not.
        for (int i = 0; i < N; i++) img[i] = ((i % W) >= 4) ? 1023 : 0;
        pulse_start(127, 1'b0);
        check_frame("step_sobel", 127, 1'b0);
        check("step_sobel_x3", wr_data[wb + 2*W + 3], 1);
        check("step_sobel_x4", wr_data[wb + 2*W + 4], 1);
        check("step_sobel_x2", wr_data[wb + 2*W + 2], 0);
        check("step_sobel_x5", wr_data[wb + 2*W + 5], 0);
        pulse_start(127, 1'b1);
        check_frame("step_prewitt", 127, 1'b1);
        check("step_prewitt_x3", wr_data[wb + 2*W + 3], 0);
        check("step_prewitt_x4", wr_data[wb + 2*W + 4], 0);

        // Abort at write 20 with a ramp image; restarted frame must be complete.
        for (int i = 0; i < N; i++) img[i] = (i * 37) % 1024;
        pulse_start(20, 1'b0);
        wait_writes("abort", 20);
        pulse_start(20, 1'b0);
        check_frame("restart", 20, 1'b0);

        // Reset at write 10 with a simultaneous start: reset must win.
        pulse_start(40, 1'b1);
        wait_writes("rst", 10);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
        start = 1'b0;
        wb = wr_n;
        db = done_n;
        repeat (60) @(negedge clk);
        check("quiet_writes", wr_n - wb, 0);
        check("quiet_done", done_n - db, 0);
        pulse_start(40, 1'b1);
        check_frame("recover", 40, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sobel_stream_edge_detector.md
Name: sobel_stream_edge_detector

Overview:
Streaming 3x3 gradient edge detector, successor to the per-pixel multi-cycle detector. Reads each frame pixel exactly once in raster order and keeps two line buffers. Emits one binary edge bit per cycle into the edge frame buffer. Dimensions, pixel width, pixel field position, memory read latency and kernel (Sobel/Prewitt) are configurable.

Parameters:
WIDTH, 640, image width in pixels (>=4)
HEIGHT, 480, image height in lines (>=3)
PIX_W, 10, pixel intensity width
DATA_W, 36, read_data width
PIX_LSB, 20, LSB of pixel field in read_data (field is [PIX_LSB+PIX_W-1:PIX_LSB])
ADDR_W, 19, address width; must be >= X_W+Y_W where X_W=$clog2(WIDTH), Y_W=$clog2(HEIGHT)
RD_LAT, 2, cycles from read_addr to valid read_data (>=1)
THRES_W, 7, threshold input width
THRES_SHIFT, 17, left shift applied to thres before compare

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins (or restarts) a frame
busy  out  1  high from cycle after start until done
done  out  1  one-cycle pulse after final write
read_addr  out  ADDR_W  source pixel address, {y,x} packed (x in low X_W bits)
read_data  in  DATA_W  source word, valid RD_LAT cycles after address
write_addr  out  ADDR_W  edge pixel address, {y,x} packed
write_data  out  1  1 = edge
write_en  out  1  write strobe, one per output pixel
thres  in  THRES_W  edge threshold, sampled on start
mode  in  1  0 = Sobel (centre weight 2), 1 = Prewitt (weight 1); sampled on start

Behaviour:
- Reset: busy=0, done=0, write_en=0, write_data=0, read_addr=0, write_addr=0, state IDLE. Reset beats simultaneous start.
- FSM: IDLE -> READ (on start) -> FLUSH (after last address W*H-1 issued) -> FINISH (after last write) -> IDLE. FINISH lasts one cycle and pulses done.
- READ: read_addr advances one pixel per cycle from (0,0); address for pixel k is issued at cycle T+1+k, where T is the start cycle. A delayed valid pipe of depth RD_LAT tags returned data.
- FLUSH: WIDTH+1 virtual zero pixels are injected at the same rate so that the bottom row and last pixel complete.
- Window: 3 shift columns fed by two WIDTH-deep line buffers. Centre (cx,cy) is complete when pixel k = cy*WIDTH+cx+WIDTH+1 arrives.
- Borders: neighbours outside the image read as 0. Column masking uses the centre's cx; no wrap between lines.
- Pipeline after window: stage 1 Gx,Gy signed PIX_W+3 bits; stage 2 squares; stage 3 sum (2*(PIX_W+3)+1 bits) compared with strict > against thres<<THRES_SHIFT, registering write_data/write_addr/write_en.
- Latency: first write_en at cycle T+WIDTH+RD_LAT+5. After that, exactly one write per cycle, raster order, WIDTH*HEIGHT writes total.
- Gx = right column minus left column, weights 1,w,1. Gy = bottom row minus top row, weights 1,w,1. w=2 for Sobel, w=1 for Prewitt.
- start while busy: abort immediately. Pipeline valids are cleared, counters restart from (0,0), and no done is emitted for the aborted frame.
- thres/mode changes while busy are ignored until the next start.

Optional Feature:
EDGE_MAG_OUT_EN
- Defined: adds output port mag [2*(PIX_W+3):0], carrying Gx^2+Gy^2 aligned with write_en. This allows threshold tuning in software.
- Undefined: port and its register are absent; only the binary edge output exists.

Decomposition:
- Package edge_pkg: state enum (IDLE, READ, FLUSH, FINISH), MODE_SOBEL=0/MODE_PREWITT=1 constants, width helper functions for gradient and magnitude widths.
- Sub-module edge_line_buffer: simple dual-port WIDTH x PIX_W RAM with one-cycle read; instantiated twice.

Test Plan:
(WIDTH=8, HEIGHT=6, RD_LAT=2, PIX_W=10, THRES_SHIFT=17 unless stated.)
1. Uniform image 100, thres=1, Sobel -> corner (0,0): Gx=Gy=300, sum 180000>131072, write_data=1; all interior pixels 0; exactly 48 write_en; done one cycle after last write.
2. Vertical step (cols 0-3=0, cols 4-7=1023), thres=127, Sobel -> interior x=3,4 give |Gx|=4092, 16744464>16646144, so 1; x=2,5 give 0. Same frame in Prewitt: 3069^2=9418761, so x=3,4 give 0.
3. Latency/order: start at cycle T -> first write_en at T+15 with write_addr 0; write_addr increments 1 per cycle in {y,x} form; busy falls with done.
4. Re-issue start at write 20 -> no done for aborted frame; 48 fresh writes starting from write_addr 0 at new T+15.
5. Assert reset at write 10 -> next cycle all outputs at reset values; no further write_en or done until a new start.
6. Compile with EDGE_MAG_OUT_EN, test-1 image -> mag=180000 at (0,0), 0 interior. Compile without -> port absent and outputs identical to test 1.
